// File: rtl/dot_product_engine.sv
// Streaming strided dot-product engine: address generator, product stage and
// accumulator with optional saturation and sticky overflow.
module dot_product_engine #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int ACC_WIDTH  = 64,
    parameter bit SIGNED     = 1'b1,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WIDTH-1:0]      len,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [ADDR_WIDTH-1:0] stride_a,
    input  logic [ADDR_WIDTH-1:0] stride_b,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  rd_en,
    input  logic [WIDTH-1:0]      rd_data_a,
    input  logic [WIDTH-1:0]      rd_data_b,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int PW = 2 * WIDTH;
    // One guard bit above the wider of accumulator and product exposes overflow.
    localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

    localparam logic signed [SW-1:0] S_MAX =
        SW'({1'b0, {(ACC_WIDTH-1){1'b1}}});
    localparam logic signed [SW-1:0] S_MIN =
        SW'(signed'({1'b1, {(ACC_WIDTH-1){1'b0}}}));
    localparam logic signed [SW-1:0] U_MAX =
        SW'({ACC_WIDTH{1'b1}});

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       len_q;
    logic [WIDTH-1:0]       idx;
    logic [ADDR_WIDTH-1:0]  stride_a_q;
    logic [ADDR_WIDTH-1:0]  stride_b_q;
    logic                   rd_en_q;
    logic                   s1_v;
    logic                   s2_v;
    logic [PW-1:0]          prod_q;
    logic [ACC_WIDTH-1:0]   acc;

    logic signed [PW-1:0]   prod_s;
    logic [PW-1:0]          prod_u;
    logic [PW-1:0]          prod;
    logic signed [SW-1:0]   prod_ext;
    logic signed [SW-1:0]   acc_ext;
    logic signed [SW-1:0]   sum;
    logic                   ovf_hi;
    logic                   ovf_lo;
    logic [ACC_WIDTH-1:0]   acc_next;

    assign rd_en = rd_en_q & en;

    always_comb begin
        prod_s   = PW'(signed'(rd_data_a)) * PW'(signed'(rd_data_b));
        prod_u   = PW'(rd_data_a) * PW'(rd_data_b);
        prod     = SIGNED ? prod_s : prod_u;
        prod_ext = SIGNED ? SW'(signed'(prod_q)) : SW'(prod_q);
        acc_ext  = SIGNED ? SW'(signed'(acc)) : SW'(acc);
        sum      = acc_ext + prod_ext;
        ovf_hi   = SIGNED ? (sum > S_MAX) : (sum > U_MAX);
        ovf_lo   = SIGNED ? (sum < S_MIN) : 1'b0;
        acc_next = ACC_WIDTH'(sum);
        if (SATURATE && ovf_hi)
            acc_next = SIGNED ? ACC_WIDTH'(S_MAX) : ACC_WIDTH'(U_MAX);
        else if (SATURATE && ovf_lo)
            acc_next = ACC_WIDTH'(S_MIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_q      <= '0;
            idx        <= '0;
            stride_a_q <= '0;
            stride_b_q <= '0;
            addr_a     <= '0;
            addr_b     <= '0;
            rd_en_q    <= 1'b0;
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            prod_q     <= '0;
            acc        <= '0;
            result     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else if (en) begin
            s1_v <= rd_en_q;
            s2_v <= s1_v;
            done <= 1'b0;
            if (s1_v)
                prod_q <= prod;
            if (s2_v) begin
                acc <= acc_next;
                if (ovf_hi || ovf_lo)
                    overflow <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= '0;
                        overflow   <= 1'b0;
                        len_q      <= len;
                        idx        <= '0;
                        addr_a     <= base_a;
                        addr_b     <= base_b;
                        stride_a_q <= stride_a;
                        stride_b_q <= stride_b;
                        busy       <= 1'b1;
                        if (len == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= '0;
                        end else begin
                            state   <= ISSUE;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (idx == len_q - 1'b1) begin
                        state   <= DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        idx    <= idx + 1'b1;
                        addr_a <= addr_a + stride_a_q;
                        addr_b <= addr_b + stride_b_q;
                    end
                end
                DRAIN: begin
                    // Last product has landed in acc once both stages are empty.
                    if (!s1_v && !s2_v) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= acc;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_engine.sv
// Scoreboard bench for dot_product_engine: default instance plus a
// 32-bit saturating instance sharing the same memory model.
module tb_dot_product_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic        start2;
    logic [31:0] len;
    logic [9:0]  base_a, base_b, stride_a, stride_b;

    logic [9:0]  addr_a, addr_b, addr_a2, addr_b2;
    logic        rd_en, rd_en2;
    logic [31:0] da, db, da2, db2;
    logic [63:0] result;
    logic [31:0] result2;
    logic        busy, done, overflow;
    logic        busy2, done2, overflow2;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];

    int     checks = 0;
    int     failures = 0;
    longint exp_q[$];

    dot_product_engine u1 (
        .clk(clk), .rst(rst), .en(en), .start(start), .len(len),
        .base_a(base_a), .base_b(base_b),
        .stride_a(stride_a), .stride_b(stride_b),
        .addr_a(addr_a), .addr_b(addr_b), .rd_en(rd_en),
        .rd_data_a(da), .rd_data_b(db), .result(result),
        .busy(busy), .done(done), .overflow(overflow)
    );

    dot_product_engine #(.ACC_WIDTH(32), .SATURATE(1'b1)) u2 (
        .clk(clk), .rst(rst), .en(en), .start(start2), .len(len),
        .base_a(base_a), .base_b(base_b),
        .stride_a(stride_a), .stride_b(stride_b),
        .addr_a(addr_a2), .addr_b(addr_b2), .rd_en(rd_en2),
        .rd_data_a(da2), .rd_data_b(db2), .result(result2),
        .busy(busy2), .done(done2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            da <= mem_a[addr_a];
            db <= mem_b[addr_b];
        end
        if (rd_en2) begin
            da2 <= mem_a[addr_a2];
            db2 <= mem_b[addr_b2];
        end
    end

    task automatic drive(input logic [31:0] l, input logic [9:0] ba,
                         input logic [9:0] bb, input logic [9:0] sa,
                         input logic [9:0] sb);
        len = l; base_a = ba; base_b = bb; stride_a = sa; stride_b = sb;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; start = 1'b0; start2 = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, rd_en, overflow} !== 4'b0 || addr_a !== 0
            || addr_b !== 0 || result !== 0) begin
            failures++;
            $display("FAIL reset_u1 busy=%b done=%b rd_en=%b ovf=%b a=%0d b=%0d res=%0h expected all 0",
                     busy, done, rd_en, overflow, addr_a, addr_b, result);
        end
        checks++;
        if ({busy2, done2, rd_en2, overflow2} !== 4'b0 || result2 !== 0) begin
            failures++;
            $display("FAIL reset_u2 busy=%b done=%b rd_en=%b ovf=%b res=%0h expected all 0",
                     busy2, done2, rd_en2, overflow2, result2);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int got = 0;
        longint e;
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 32'(i + 1);
            mem_b[16 + i] = 32'(i + 5);
        end
        @(negedge clk);
        drive(4, 0, 16, 1, 1); start = 1'b1; exp_q.push_back(70);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (c <= 4) begin
                checks++;
                if (addr_a !== 10'(c - 1) || rd_en !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_addr cycle=%0d addr_a=%0d rd_en=%b expected %0d/1",
                             c, addr_a, rd_en, c - 1);
                end
            end
            if (done) begin got = c; break; end
            @(negedge clk);
        end
        checks++;
        if (got != 8) begin
            failures++;
            $display("FAIL basic_latency done_cycle=%0d expected 8", got);
        end
        e = exp_q.pop_front();
        checks++;
        if (result !== e) begin
            failures++;
            $display("FAIL basic_result got=%0d expected %0d", result, e);
        end
    endtask

    task automatic test_len_zero;
        longint e;
        @(negedge clk);
        drive(0, 5, 5, 1, 1); start = 1'b1; exp_q.push_back(0);
        @(negedge clk);
        start = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || result !== e || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL len0_done done=%b res=%0d rd_en=%b expected 1/%0d/0",
                     done, result, rd_en, e);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL len0_after done=%b rd_en=%b busy=%b expected 0/0/0",
                     done, rd_en, busy);
        end
    endtask

    task automatic test_signed;
        int got = 0;
        longint e;
        mem_a[40] = -32'sd3; mem_a[41] = 32'sd4;
        mem_b[50] = 32'sd5;  mem_b[51] = -32'sd6;
        @(negedge clk);
        drive(2, 40, 50, 1, 1); start = 1'b1; exp_q.push_back(-39);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (done) begin got = c; break; end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if (got != 6 || result !== e) begin
            failures++;
            $display("FAIL signed_result got=%0h cycle=%0d expected %0h cycle 6",
                     result, got, e);
        end
    endtask

    task automatic test_saturate;
        int got = 0;
        longint e;
        mem_a[60] = 32'hFFFF; mem_a[61] = 32'hFFFF;
        mem_b[70] = 32'hFFFF; mem_b[71] = 32'hFFFF;
        mem_a[62] = 7; mem_b[72] = 3;
        @(negedge clk);
        drive(2, 60, 70, 1, 1); start2 = 1'b1; exp_q.push_back(32'h7FFF_FFFF);
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (done2) begin got = c; break; end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if (got != 6 || result2 !== 32'(e) || overflow2 !== 1'b1) begin
            failures++;
            $display("FAIL sat_clamp res=%0h ovf=%b cycle=%0d expected %0h/1 cycle 6",
                     result2, overflow2, got, e);
        end
        @(negedge clk);
        drive(1, 62, 72, 1, 1); start2 = 1'b1; exp_q.push_back(21);
        @(negedge clk);
        start2 = 1'b0;
        #1;
        checks++;
        if (overflow2 !== 1'b0) begin
            failures++;
            $display("FAIL sat_ovf_clear ovf=%b expected 0", overflow2);
        end
        got = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) #1;
            if (done2) begin got = c; break; end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if (got != 5 || result2 !== 32'(e)) begin
            failures++;
            $display("FAIL sat_second res=%0d cycle=%0d expected %0d cycle 5",
                     result2, got, e);
        end
    endtask

    task automatic test_stall;
        int got = 0;
        longint e;
        for (int i = 0; i < 8; i++) begin
            mem_a[100 + i] = 32'(i + 1);
            mem_b[200 + i] = 2;
        end
        @(negedge clk);
        drive(8, 100, 200, 1, 1); start = 1'b1; exp_q.push_back(72);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            en = !(c >= 3 && c <= 5);
            #1;
            if (c == 4) begin
                checks++;
                if (rd_en !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_rd_en rd_en=%b expected 0", rd_en);
                end
            end
            if (done) begin got = c; break; end
            @(negedge clk);
        end
        en = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (got != 15 || result !== e) begin
            failures++;
            $display("FAIL stall_result res=%0d cycle=%0d expected %0d cycle 15",
                     result, got, e);
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        @(negedge clk);
        drive(8, 100, 200, 1, 1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            rst = (c == 5);
            if (c < 6) @(negedge clk);
        end
        #1;
        checks++;
        if ({busy, done, rd_en, overflow} !== 4'b0 || addr_a !== 0
            || addr_b !== 0 || result !== 0) begin
            failures++;
            $display("FAIL reset_mid_outputs busy=%b done=%b rd_en=%b ovf=%b a=%0d b=%0d res=%0d expected all 0",
                     busy, done, rd_en, overflow, addr_a, addr_b, result);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done active_cycles=%0d expected 0", seen);
        end
    endtask

    task automatic test_wrap;
        int got = 0;
        longint e;
        logic [9:0] wa [3];
        wa[0] = 10'd1020; wa[1] = 10'd1023; wa[2] = 10'd2;
        mem_a[1020] = 1; mem_a[1023] = 2; mem_a[2] = 3; mem_b[300] = 10;
        @(negedge clk);
        drive(3, 1020, 300, 3, 0); start = 1'b1; exp_q.push_back(60);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 2) begin len = 5; start = 1'b1; end
            else start = 1'b0;
            #1;
            if (c <= 3) begin
                checks++;
                if (addr_a !== wa[c-1]) begin
                    failures++;
                    $display("FAIL wrap_addr cycle=%0d addr_a=%0d expected %0d",
                             c, addr_a, wa[c-1]);
                end
            end
            if (done) begin got = c; break; end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if (got != 7 || result !== e) begin
            failures++;
            $display("FAIL wrap_result res=%0d cycle=%0d expected %0d cycle 7",
                     result, got, e);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int got;
        longint e;
        mem_a[400] = 2; mem_a[401] = 3; mem_b[500] = 4; mem_b[501] = 5;
        exp_q.push_back(23);
        exp_q.push_back(8);
        for (int r = 0; r < 2; r++) begin
            if (r == 0) @(negedge clk);
            else begin
                @(negedge clk);
            end
            drive((r == 0) ? 2 : 1, 400, 500, 1, 1); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            got = 0;
            for (int c = 1; c <= 40; c++) begin
                #1;
                if (done) begin got = c; break; end
                @(negedge clk);
            end
            e = exp_q.pop_front();
            checks++;
            if (got != ((r == 0) ? 6 : 5) || result !== e) begin
                failures++;
                $display("FAIL b2b_run%0d res=%0d cycle=%0d expected %0d cycle %0d",
                         r, result, got, e, (r == 0) ? 6 : 5);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        test_reset;
        test_basic;
        test_len_zero;
        test_signed;
        test_saturate;
        test_stall;
        test_reset_mid;
        test_wrap;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
